lfsr_stream_checker: RTL and testbench
======================================

Name: lfsr_stream_checker

Overview:
- Receive-side counterpart of the team's 12-bit Fibonacci LFSR generator.
- Consumes the generator's serial output one bit per strobe.
- Self-synchronises to the sequence, declares lock, then flags and counts bit errors against its own free-running prediction.
- Used on the board to prove the pseudo-random source and its wiring end to end.

Parameters:
- WIDTH, 12: LFSR length in bits.
- TAP_A, 11: first feedback tap, index into the history register.
- TAP_B, 10: second feedback tap.
- LOCK_COUNT, 16: consecutive correct predictions required to declare lock.
- LOSS_COUNT, 4: consecutive mispredictions in LOCKED that drop lock.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_valid  in  1  qualifies bit_in; one bit consumed per cycle when high.
- bit_in  in  1  serial LFSR bit from generator.
- clear_errs  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- bit_err  out  1  one-cycle pulse on a misprediction while LOCKED.
- err_count  out  ERR_W  saturating count of bit_err pulses.
- state  out  2  encoded FSM state, for debug LEDs.

Behaviour:
- Stream definition: b[n] = b[n-1-TAP_A] XOR b[n-1-TAP_B]. With the defaults this is b[n] = b[n-12] XOR b[n-11].
- History register hist[WIDTH-1:0]: a new bit shifts into bit 0 and hist[k] = b[n-1-k]. Prediction p = hist[TAP_A] ^ hist[TAP_B].
- Reset: state=SEARCH; hist, fill/match/miss counters, locked, bit_err and err_count all 0.
- All logic advances only on cycles with bit_valid=1. Cycles with bit_valid=0 hold all state, and bit_err is 0 on those cycles.
- SEARCH (state=0):
  - Shift bit_in into hist and increment fill.
  - On the valid bit that brings fill to WIDTH, move to VERIFY with match=0.
- VERIFY (state=1):
  - Compare bit_in with p, then shift bit_in in. The received bit is used, which gives self-synchronisation.
  - Match with hist nonzero: match+1.
  - Mismatch, or hist all-zero: match=0. This is the lock-up guard, so an all-zero stream never locks.
  - When match reaches LOCK_COUNT, go to LOCKED. locked is registered and goes high at the same clock edge as the transition.
- LOCKED (state=2):
  - Compare bit_in with p, then shift p in, not bit_in (flywheel). An isolated error therefore does not corrupt the prediction.
  - On a mismatch: bit_err=1 for that cycle, err_count+1 (saturating at all-ones), miss+1.
  - On a match: miss=0.
  - When miss reaches LOSS_COUNT, go to SEARCH with fill=0, match=0, miss=0. locked falls at that edge.
  - The LOSS_COUNT-th error still pulses bit_err and counts.
- Latency: bit_err, locked and err_count are registered. Each is visible the cycle after the clock edge that sampled the bit.
- clear_errs:
  - Zeroes err_count in any state.
  - If asserted in the same cycle as a counted error, the clear wins and the result is 0.
  - Has no effect on the FSM.
- state encoding 3 is unused and recovers to SEARCH.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous).

Optional Feature:
- Macro LFSR_CHK_RESYNC_EN.
- Defined: in LOCKED, each mismatch shifts bit_in instead of p. Loss of lock then re-enters VERIFY (match=0) directly with the current hist, not SEARCH. Faster recovery after a generator reseed.
- Undefined: flywheel and SEARCH re-entry exactly as described in Behaviour.

Decomposition:
- Shared package lfsr_pkg:
  - state encoding constants ST_SEARCH=2'd0, ST_VERIFY=2'd1, ST_LOCKED=2'd2;
  - default WIDTH/TAP constants, shared with the generator;
  - default seed 12'hB76.
- One natural sub-module, lfsr_predictor: holds hist, computes p, and shifts either bit_in or p according to a select input.
- The FSM and counters stay in the top level.

Test Plan:
- Reset, then 12 valid bits of a correct stream followed by 16 further correct bits → locked=1 the cycle after the 28th valid bit, err_count=0, state=2.
- After lock, invert one bit → bit_err high for exactly one cycle, err_count=1, locked stays 1. The following correct bits give no further errors, confirming the flywheel.
- After lock, invert 4 consecutive bits → 4 bit_err pulses, err_count=4, locked=0 and state=0 after the 4th. Re-lock occurs after 28 further correct bits.
- 200 valid zero bits from reset → never locked, state toggles only SEARCH→VERIFY and stays in VERIFY with match=0.
- Correct stream with bit_valid low on alternate cycles, plus 5 idle cycles inserted mid-VERIFY → lock at the same valid-bit count as the gapless case, no bit_err.
- While locked with err_count=3: assert clear_errs coincident with an error → err_count=0. Then pulse rst_n low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the 12-bit Fibonacci LFSR generator and its stream checker.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 12;
  localparam int unsigned LFSR_TAP_A = 11;
  localparam int unsigned LFSR_TAP_B = 10;

  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 12'hB76;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_SEARCH = 2'd0;
  localparam logic [ST_W-1:0] ST_VERIFY = 2'd1;
  localparam logic [ST_W-1:0] ST_LOCKED = 2'd2;

endpackage : lfsr_pkg

// File: rtl/lfsr_predictor.sv
// History register of the received stream plus next-bit prediction.
// The shifted bit is either the received bit or the prediction (flywheel).
module lfsr_predictor
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_WIDTH,
  parameter int unsigned TAP_A = LFSR_TAP_A,
  parameter int unsigned TAP_B = LFSR_TAP_B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             sel_pred_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] hist_o,
  output logic             pred_c_o
);

  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;
  logic             shift_bit_c;

  assign pred_c_o = hist_q[TAP_A] ^ hist_q[TAP_B];
  assign hist_o   = hist_q;

  // hist[k] holds the bit received k+1 strobes ago
  always_comb begin
    hist_d      = hist_q;
    shift_bit_c = sel_pred_i ? pred_c_o : bit_i;
    if (advance_i) begin
      hist_d = {hist_q[WIDTH-2:0], shift_bit_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule : lfsr_predictor

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the serial 12-bit LFSR stream: SEARCH/VERIFY/LOCKED
// with error pulse and saturating error count. Macro LFSR_CHK_RESYNC_EN enables resync-on-loss.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH      = LFSR_WIDTH,
  parameter int unsigned TAP_A      = LFSR_TAP_A,
  parameter int unsigned TAP_B      = LFSR_TAP_B,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_errs,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic [ST_W-1:0]  state
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

  logic [ST_W-1:0]    state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc_c;
  logic [MATCH_W-1:0] match_q, match_d, match_inc_c;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc_c;
  logic               locked_q, locked_d;
  logic               bit_err_q, bit_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0]   hist_c;
  logic               pred_c;
  logic               mismatch_c;
  logic               hist_zero_c;
  logic               shift_pred_c;

  lfsr_predictor #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_pred (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance_i  (bit_valid),
    .sel_pred_i (shift_pred_c),
    .bit_i      (bit_in),
    .hist_o     (hist_c),
    .pred_c_o   (pred_c)
  );

  assign mismatch_c  = bit_in ^ pred_c;
  assign hist_zero_c = (hist_c == '0);
  assign fill_inc_c  = fill_q + FILL_W'(1);
  assign match_inc_c = match_q + MATCH_W'(1);
  assign miss_inc_c  = miss_q + MISS_W'(1);

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    match_d      = match_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    bit_err_d    = 1'b0;
    err_count_d  = err_count_q;
    shift_pred_c = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (bit_valid) begin
          if (fill_inc_c == FILL_W'(WIDTH)) begin
            state_d = ST_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_inc_c;
          end
        end
      end

      // An all-zero history is the LFSR lock-up state and must never count as a match
      ST_VERIFY: begin
        if (bit_valid) begin
          if (mismatch_c || hist_zero_c) begin
            match_d = '0;
          end else if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            match_d  = '0;
            miss_d   = '0;
          end else begin
            match_d = match_inc_c;
          end
        end
      end

      ST_LOCKED: begin
        shift_pred_c = 1'b1;
        if (bit_valid) begin
          if (mismatch_c) begin
`ifdef LFSR_CHK_RESYNC_EN
            shift_pred_c = 1'b0;
`endif
            bit_err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_inc_c == MISS_W'(LOSS_COUNT)) begin
`ifdef LFSR_CHK_RESYNC_EN
              state_d = ST_VERIFY;
`else
              state_d = ST_SEARCH;
`endif
              locked_d = 1'b0;
              fill_d   = '0;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc_c;
            end
          end else begin
            miss_d = '0;
          end
        end
      end

      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
        fill_d   = '0;
        match_d  = '0;
        miss_d   = '0;
      end
    endcase

    // Clear has priority over a coincident counted error
    if (clear_errs) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule : lfsr_stream_checker

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: lock, flywheel, loss/re-lock, zero stream,
// gapped strobes, clear priority and asynchronous reset.
module tb_lfsr_stream_checker;
  import lfsr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        bit_valid;
  logic        bit_in;
  logic        clear_errs;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;
  logic [1:0]  state;

  int n_cmp;
  int n_bad;
  int err_seen;
  logic [11:0] g;

  lfsr_stream_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clear_errs (clear_errs),
    .locked     (locked),
    .bit_err    (bit_err),
    .err_count  (err_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator: b[n] = b[n-12] ^ b[n-11], continuing from the seed history
  function automatic logic gen_bit();
    logic nb;
    nb = g[11] ^ g[10];
    g  = {g[10:0], nb};
    return nb;
  endfunction

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic step(input logic v, input logic b, input logic clr);
    bit_valid  = v;
    bit_in     = b;
    clear_errs = clr;
    @(posedge clk);
    #1;
    if (bit_err === 1'b1) err_seen++;
    bit_valid  = 1'b0;
    clear_errs = 1'b0;
  endtask

  task automatic do_reset();
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    g        = LFSR_SEED;
    err_seen = 0;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) step(1'b1, gen_bit(), 1'b0);
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clear_errs = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (bit_err !== 1'b0) begin n_bad++; $display("FAIL reset_bit_err: got %b want 0", bit_err); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_lock();
    do_reset();
    send_good(12);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL lock_verify_after12: got %0d want 1", state); end
    send_good(15);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early_27: got %b want 0", locked); end
    send_good(1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_at_28: got %b want 1", locked); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL lock_state: got %0d want 2", state); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL lock_err_count: got %0d want 0", err_count); end
    n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL lock_no_bit_err: got %0d pulses want 0", err_seen); end
  endtask

  task automatic test_single_error();
    step(1'b1, ~gen_bit(), 1'b0);
    n_cmp++; if (bit_err !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %b want 1", bit_err); end
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %b want 1", locked); end
    send_good(1);
    n_cmp++; if (bit_err !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle: got %b want 0", bit_err); end
    err_seen = 0;
    send_good(20);
    n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL flywheel_no_errs: got %0d pulses want 0", err_seen); end
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL flywheel_count: got %0d want 1", err_count); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL flywheel_state: got %0d want 2", state); end
  endtask

  task automatic test_loss_relock();
    do_reset();
    send_good(28);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, ~gen_bit(), 1'b0);
      n_cmp++; if (bit_err !== 1'b1) begin n_bad++; $display("FAIL loss_pulse%0d: got %b want 1", i, bit_err); end
      if (i == 3) begin
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_held_3: got %b want 1", locked); end
      end
    end
    n_cmp++; if (err_count !== 16'd4) begin n_bad++; $display("FAIL loss_count: got %0d want 4", err_count); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked: got %b want 0", locked); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL loss_state: got %0d want 0", state); end
    send_good(27);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_early_27: got %b want 0", locked); end
    send_good(1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_at_28: got %b want 1", locked); end
    n_cmp++; if (err_count !== 16'd4) begin n_bad++; $display("FAIL relock_count: got %0d want 4", err_count); end
  endtask

  task automatic test_zero_stream();
    int ever_locked;
    int left_verify;
    ever_locked = 0;
    left_verify = 0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0 || state === 2'd2) ever_locked++;
      if (i > 12 && state !== 2'd1) left_verify++;
    end
    n_cmp++; if (ever_locked !== 0) begin n_bad++; $display("FAIL zeros_never_lock: got %0d locked cycles want 0", ever_locked); end
    n_cmp++; if (left_verify !== 0) begin n_bad++; $display("FAIL zeros_stay_verify: got %0d off cycles want 0", left_verify); end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL zeros_state: got %0d want 1", state); end
    n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL zeros_bit_err: got %0d pulses want 0", err_seen); end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      if (i == 27) begin
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL gaps_early_27: got %b want 0", locked); end
      end
      if (i < 28) step(1'b0, 1'($urandom_range(1)), 1'b0);
      if (i == 18) begin
        for (int k = 0; k < 5; k++) step(1'b0, 1'($urandom_range(1)), 1'b0);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL gaps_idle_hold: got %0d want 1", state); end
      end
    end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gaps_lock_28: got %b want 1", locked); end
    n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL gaps_bit_err: got %0d pulses want 0", err_seen); end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gaps_idle_locked: got %b want 1", locked); end
  endtask

  task automatic test_clear_and_async_reset();
    do_reset();
    send_good(28);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ~gen_bit(), 1'b0);
      send_good(1);
    end
    n_cmp++; if (err_count !== 16'd3) begin n_bad++; $display("FAIL clear_pre_count: got %0d want 3", err_count); end
    step(1'b1, ~gen_bit(), 1'b1);
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clear_wins: got %0d want 0", err_count); end
    n_cmp++; if (bit_err !== 1'b1) begin n_bad++; $display("FAIL clear_pulse: got %b want 1", bit_err); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clear_fsm: got %b want 1", locked); end
    send_good(2);
    step(1'b1, ~gen_bit(), 1'b0);
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL post_clear_count: got %0d want 1", err_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL async_locked: got %b want 0", locked); end
    n_cmp++; if (bit_err !== 1'b0) begin n_bad++; $display("FAIL async_bit_err: got %b want 0", bit_err); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL async_err_count: got %0d want 0", err_count); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL async_state: got %0d want 0", state); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    err_seen = 0;
    g        = LFSR_SEED;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_zero_stream();
    test_gaps();
    test_clear_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lfsr_stream_checker
